// File: rtl/ccta_pkg.sv
// ----------------------------------------------------------------------------
// ccta_pkg
//
// Shared definitions for the ccta_core conditional-compute arithmetic block.
//
// Contents:
//   DATA_W         default operand width (unsigned operands A, B, C)
//   Q_W            result width, one bit wider than DATA_W to hold the carry
//   MODE_ADD_AB    ctrl encoding for q = A + B
//   MODE_MAX_ADD_C ctrl encoding for q = max(A,B) + C
//   Q_RST          value the result register takes under reset
//
// Optional build feature (selected in ccta_core): CCTA_INREG_EN adds an
// input register stage in front of the arithmetic.
// ----------------------------------------------------------------------------
package ccta_pkg;

    localparam int DATA_W = 4;
    localparam int Q_W    = DATA_W + 1;

    // Mode select encodings driven on ctrl.
    localparam logic MODE_ADD_AB    = 1'b0;
    localparam logic MODE_MAX_ADD_C = 1'b1;

    // Result register reset value.
    localparam logic [Q_W-1:0] Q_RST = '0;

endpackage : ccta_pkg

// File: rtl/ccta_max.sv
// ----------------------------------------------------------------------------
// ccta_max
//
// Combinational unsigned maximum selector. Ties select operand A; the value
// is the same either way, but a fixed choice keeps the mux select stable
// for equivalence checking.
//
// Ports:
//   a_i    [DATA_W-1:0]  unsigned operand A
//   b_i    [DATA_W-1:0]  unsigned operand B
//   max_o  [DATA_W-1:0]  max(a_i, b_i)
// ----------------------------------------------------------------------------
module ccta_max #(
    parameter int DATA_W = ccta_pkg::DATA_W
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] max_o
);

    assign max_o = (a_i >= b_i) ? a_i : b_i;

endmodule : ccta_max

// File: rtl/ccta_core.sv
// ----------------------------------------------------------------------------
// ccta_core
//
// Registered conditional-compute arithmetic stage. Every rising edge the
// result register loads either A + B (ctrl = MODE_ADD_AB) or max(A,B) + C
// (ctrl = MODE_MAX_ADD_C). All operands are unsigned and zero-extended to
// Q_W before the add, so the full range 0..2*(2^DATA_W-1) fits without
// overflow. C does not affect the result in ADD_AB mode.
//
// Interface: there is no handshake. The block computes unconditionally on
// every edge; q is driven straight from a register, so there is no
// combinational path from any input to q.
//
// Ports:
//   clk   in   1        rising-edge clock
//   rst   in   1        synchronous, active-high reset (clears all state)
//   A     in   DATA_W   unsigned operand A
//   B     in   DATA_W   unsigned operand B
//   C     in   DATA_W   unsigned operand C (MAX_ADD_C mode only)
//   ctrl  in   1        mode select: 0 = ADD_AB, 1 = MAX_ADD_C
//   q     out  Q_W      registered result
//
// Build option:
//   CCTA_INREG_EN  when defined, A/B/C/ctrl are first captured in input
//                  registers (reset to 0) and latency grows from 1 to 2
//                  cycles. The arithmetic is identical in both builds.
// ----------------------------------------------------------------------------
module ccta_core
    import ccta_pkg::*;
#(
    parameter int DATA_W = ccta_pkg::DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   A,
    input  logic [DATA_W-1:0]   B,
    input  logic [DATA_W-1:0]   C,
    input  logic                ctrl,
    output logic [DATA_W:0]     q
);

    localparam int Q_W_L = DATA_W + 1;

    // Operands as seen by the arithmetic (raw ports or captured copies).
    logic [DATA_W-1:0] a_s;
    logic [DATA_W-1:0] b_s;
    logic [DATA_W-1:0] c_s;
    logic              ctrl_s;

`ifdef CCTA_INREG_EN
    // Input stage: the operands and the mode are captured together, so a
    // mode change always travels with the operands it was sampled with.
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] c_q;
    logic              ctrl_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= '0;
            ctrl_q <= 1'b0;
        end else begin
            a_q    <= A;
            b_q    <= B;
            c_q    <= C;
            ctrl_q <= ctrl;
        end
    end

    assign a_s    = a_q;
    assign b_s    = b_q;
    assign c_s    = c_q;
    assign ctrl_s = ctrl_q;
`else
    assign a_s    = A;
    assign b_s    = B;
    assign c_s    = C;
    assign ctrl_s = ctrl;
`endif

    // Larger of the two primary operands.
    logic [DATA_W-1:0] max_ab;

    ccta_max #(
        .DATA_W (DATA_W)
    ) u_max (
        .a_i   (a_s),
        .b_i   (b_s),
        .max_o (max_ab)
    );

    // Mode mux selects the first addend and the second addend; a single
    // Q_W-wide adder then serves both modes.
    logic [DATA_W-1:0] add_x;
    logic [DATA_W-1:0] add_y;
    logic [Q_W_L-1:0]  q_d;
    logic [Q_W_L-1:0]  q_q;

    always_comb begin
        add_x = a_s;
        add_y = b_s;
        if (ctrl_s == MODE_MAX_ADD_C) begin
            add_x = max_ab;
            add_y = c_s;
        end
        q_d = Q_W_L'(add_x) + Q_W_L'(add_y);
    end

    // Result register; reset overrides and discards the pending result.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= Q_W_L'(Q_RST);
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule : ccta_core

// File: tb/tb_ccta_core.sv
// ----------------------------------------------------------------------------
// tb_ccta_core
//
// Self-checking bench for ccta_core. Inputs are driven on the falling edge,
// q is sampled 1 time unit after each rising edge. A reference model keeps a
// queue of results in flight (depth set by the build's latency) and is
// checked after every edge; table vectors and short sequences additionally
// check fixed values.
// ----------------------------------------------------------------------------
module tb_ccta_core;

`ifdef CCTA_INREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int W  = 4;
    localparam int QW = W + 1;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  A = '0;
    logic [W-1:0]  B = '0;
    logic [W-1:0]  C = '0;
    logic          ctrl = 1'b0;
    logic [QW-1:0] q;

    always #5 clk = ~clk;

    ccta_core #(.DATA_W(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .A    (A),
        .B    (B),
        .C    (C),
        .ctrl (ctrl),
        .q    (q)
    );

    // ---------------- scoreboard ----------------
    int            total = 0;
    int            bad   = 0;
    logic [QW-1:0] exp_q[$];

    function automatic logic [QW-1:0] ref_f(input int a, input int b,
                                            input int c, input logic m);
        int mx;
        mx = (a >= b) ? a : b;
        if (m) return QW'(mx + c);
        return QW'(a + b);
    endfunction

    task automatic check(input string nm, input logic [QW-1:0] got,
                         input logic [QW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: q=%0d expected=%0d", nm, got, exp);
        end
    endtask

    // ---------------- driver ----------------
    // One clock edge with the given inputs; model advances and q is checked.
    task automatic step(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] c, input logic m, input logic r,
                        input string nm);
        logic [QW-1:0] e;
        @(negedge clk);
        A = a; B = b; C = c; ctrl = m; rst = r;
        @(posedge clk);
        if (r) begin
            exp_q.delete();
            for (int i = 0; i < LAT - 1; i++) exp_q.push_back('0);
            e = '0;
        end else begin
            exp_q.push_back(ref_f(int'(a), int'(b), int'(c), m));
            e = exp_q.pop_front();
        end
        #1;
        check(nm, q, e);
    endtask

    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [W-1:0]  c;
        logic          m;
        logic [QW-1:0] exp;
        string         nm;
    } vec_t;

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{4'd3,  4'd13, 4'd7,  1'b0, 5'd16, "add_3_13"};
        tbl[1]  = '{4'd5,  4'd2,  4'd15, 1'b0, 5'd7,  "add_5_2"};
        tbl[2]  = '{4'd13, 4'd6,  4'd0,  1'b0, 5'd19, "add_13_6"};
        tbl[3]  = '{4'd13, 4'd12, 4'd9,  1'b0, 5'd25, "add_13_12"};
        tbl[4]  = '{4'd6,  4'd5,  4'd10, 1'b1, 5'd16, "max_6_5_10"};
        tbl[5]  = '{4'd5,  4'd7,  4'd2,  1'b1, 5'd9,  "max_5_7_2"};
        tbl[6]  = '{4'd15, 4'd2,  4'd14, 1'b1, 5'd29, "max_15_2_14"};
        tbl[7]  = '{4'd15, 4'd15, 4'd15, 1'b0, 5'd30, "ext_add_15"};
        tbl[8]  = '{4'd15, 4'd15, 4'd15, 1'b1, 5'd30, "ext_max_15"};
        tbl[9]  = '{4'd0,  4'd0,  4'd0,  1'b0, 5'd0,  "ext_zero_add"};
        tbl[10] = '{4'd0,  4'd0,  4'd0,  1'b1, 5'd0,  "ext_zero_max"};
        tbl[11] = '{4'd7,  4'd7,  4'd1,  1'b1, 5'd8,  "tie_7_7_1"};

        // Reset with nonzero operands: q stays 0.
        for (int i = 0; i < 2; i++) step(4'd4, 4'd1, 4'd9, 1'b0, 1'b1, "rst_hold");
        check("rst_q0", q, 5'd0);
        // Release: first result after LAT edges.
        for (int i = 0; i < LAT; i++) step(4'd4, 4'd1, 4'd9, 1'b0, 1'b0, "rst_release");
        check("rst_first", q, 5'd5);

        // Table vectors, each held for LAT edges.
        for (int v = 0; v < 12; v++) begin
            for (int i = 0; i < LAT; i++)
                step(tbl[v].a, tbl[v].b, tbl[v].c, tbl[v].m, 1'b0, tbl[v].nm);
            check(tbl[v].nm, q, tbl[v].exp);
        end

        // C ignored in ADD_AB: change only C on consecutive edges.
        for (int i = 0; i < LAT + 3; i++)
            step(4'd13, 4'd12, W'($urandom_range(0, 15)), 1'b0, 1'b0, "c_ignored");
        check("c_ignored_val", q, 5'd25);

        // Mode switch on consecutive edges: 25 then 22.
        for (int i = 0; i < LAT; i++) step(4'd13, 4'd12, 4'd9, 1'b0, 1'b0, "sw_add");
        check("sw_25", q, 5'd25);
        step(4'd13, 4'd12, 4'd9, 1'b1, 1'b0, "sw_max");
        if (LAT == 1) check("sw_22", q, 5'd22);
        else check("sw_still_25", q, 5'd25);
        for (int i = 1; i < LAT; i++) step(4'd13, 4'd12, 4'd9, 1'b1, 1'b0, "sw_max2");
        check("sw_22_final", q, 5'd22);

        // Mid-stream reset discards the pending result.
        step(4'd15, 4'd15, 4'd0, 1'b0, 1'b1, "mid_rst");
        check("mid_rst_q0", q, 5'd0);
        for (int i = 0; i < LAT; i++) step(4'd15, 4'd15, 4'd0, 1'b0, 1'b0, "mid_after");
        check("mid_after_30", q, 5'd30);

        // Randomized stream with occasional resets against the model.
        for (int i = 0; i < 400; i++)
            step(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)),
                 W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 19) == 0), "random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_ccta_core
